// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit:
// FSM states, op classes, ALU commands, condition codes and mux selects.
package mcu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXECR  = 4'd2,
    EXECI  = 4'd3,
    ALUWB  = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic       SRCA_RN    = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Compare-class commands only set flags and never write a register.
  function automatic logic is_compare(input logic [3:0] cmd);
    return (cmd[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/flag inputs and datapath control outputs of the control unit.
interface multicycle_control_unit_if #(parameter int ALU_W = 4);
  logic [3:0]       cond;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic [3:0]       alu_flags;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [ALU_W-1:0] alu_control;
  logic [1:0]       imm_src;
  logic             reg_write;
  logic [1:0]       reg_src;
  logic             link_sel;
  logic [3:0]       flags_q;
  logic [3:0]       state_q;

  modport master (
    output cond, op, funct, alu_flags, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, reg_src, link_sel, flags_q, state_q
  );

  modport slave (
    input  cond, op, funct, alu_flags, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_control, imm_src, reg_write, reg_src, link_sel, flags_q, state_q
  );
endinterface

// File: rtl/multicycle_control_unit_cond_eval.sv
// ARM condition-code evaluation against the NZCV flags; 1111 never passes.
module cond_eval_unit
  import mcu_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

  // Condition decode table
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle Moore control unit: sequences fetch/decode/execute/memory/writeback
// and owns the NZCV register. Write enables are gated off while rst is low.
module multicycle_control_unit
  import mcu_ctrl_pkg::*;
#(
  parameter int ALU_W         = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.slave  bus
);
  state_t     r_state;
  logic [3:0] r_flags;
  logic       w_pass;
  logic       w_ready;
  logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_link_sel;
  logic       w_adr_src, w_alu_src_a;
  logic [1:0] w_result_src, w_alu_src_b;
  logic [3:0] w_alu_cmd;

  assign w_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  cond_eval_unit u_cond (
    .i_cond  (bus.cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  // State sequencing and flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_flags <= 4'b0000;
    end else begin
      case (r_state)
        FETCH:  r_state <= w_ready ? DECODE : FETCH;
        DECODE: begin
          if (!w_pass) begin
            r_state <= FETCH;
          end else begin
            case (bus.op)
              OP_DP:   r_state <= bus.funct[5] ? EXECI : EXECR;
              OP_MEM:  r_state <= MEMADR;
              OP_BR:   r_state <= BRANCH;
              default: r_state <= FETCH;
            endcase
          end
        end
        EXECR, EXECI: begin
          if (bus.funct[0]) begin
            r_flags <= bus.alu_flags;
          end
          r_state <= is_compare(bus.funct[4:1]) ? FETCH : ALUWB;
        end
        ALUWB:  r_state <= FETCH;
        MEMADR: r_state <= bus.funct[0] ? MEMRD : MEMWR;
        MEMRD:  r_state <= w_ready ? MEMWB : MEMRD;
        MEMWB:  r_state <= FETCH;
        MEMWR:  r_state <= w_ready ? FETCH : MEMWR;
        BRANCH: r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Per-state datapath control decode
  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_link_sel   = 1'b0;
    w_adr_src    = ADR_PC;
    w_alu_src_a  = SRCA_RN;
    w_alu_src_b  = SRCB_RM;
    w_result_src = RES_ALUOUT;
    w_alu_cmd    = CMD_ADD;
    case (r_state)
      FETCH: begin
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_ir_write   = w_ready;
        w_pc_write   = w_ready;
      end
      DECODE: begin
        w_alu_src_a = SRCA_PC;
        w_alu_src_b = SRCB_FOUR;
      end
      EXECR: w_alu_cmd = bus.funct[4:1];
      EXECI: begin
        w_alu_cmd   = bus.funct[4:1];
        w_alu_src_b = SRCB_IMM;
      end
      ALUWB: w_reg_write = 1'b1;
      MEMADR: begin
        w_alu_src_b = SRCB_IMM;
        w_alu_cmd   = bus.funct[3] ? CMD_ADD : CMD_SUB;
      end
      MEMRD: w_adr_src = ADR_ALUOUT;
      MEMWB: begin
        w_result_src = RES_RDATA;
        w_reg_write  = 1'b1;
      end
      MEMWR: begin
        w_adr_src   = ADR_ALUOUT;
        w_mem_write = 1'b1;
      end
      BRANCH: begin
        // ALUOut still holds PC+4 from DECODE, which becomes the link value.
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALU;
        w_pc_write   = 1'b1;
        w_reg_write  = bus.funct[4];
        w_link_sel   = bus.funct[4];
      end
      default: w_pc_write = 1'b0;
    endcase
  end

  assign bus.pc_write    = w_pc_write & rst;
  assign bus.ir_write    = w_ir_write & rst;
  assign bus.mem_write   = w_mem_write & rst;
  assign bus.reg_write   = w_reg_write & rst;
  assign bus.link_sel    = w_link_sel;
  assign bus.adr_src     = w_adr_src;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.result_src  = w_result_src;
  assign bus.alu_control = ALU_W'(w_alu_cmd);
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {(bus.op == OP_BR), (bus.op == OP_MEM)};
  assign bus.flags_q     = r_flags;
  assign bus.state_q     = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven check of the multicycle control unit, plus a mid-instruction reset sequence.
module tb_multicycle_control_unit;
  import mcu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_unit_if #(.ALU_W(4)) bus ();

  multicycle_control_unit #(.ALU_W(4), .MEM_HANDSHAKE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // {op, funct, cond}
  localparam logic [11:0] I_ADD  = {2'b00, 6'b101000, 4'b1110};
  localparam logic [11:0] I_SUBS = {2'b00, 6'b000101, 4'b1110};
  localparam logic [11:0] I_BEQ  = {2'b10, 6'b000000, 4'b0000};
  localparam logic [11:0] I_BNE  = {2'b10, 6'b000000, 4'b0001};
  localparam logic [11:0] I_CMP  = {2'b00, 6'b010101, 4'b1110};
  localparam logic [11:0] I_LDR  = {2'b01, 6'b010001, 4'b0100};
  localparam logic [11:0] I_STR  = {2'b01, 6'b011000, 4'b1110};
  localparam logic [11:0] I_BL   = {2'b10, 6'b010000, 4'b1110};
  localparam logic [11:0] I_UND  = {2'b11, 6'b000000, 4'b1110};
  localparam logic [11:0] I_NV   = {2'b00, 6'b101000, 4'b1111};

  typedef struct {
    logic [11:0] ins;
    logic [3:0]  af;
    logic        mr;
    state_t      st;
    logic [14:0] ctrl;
    logic [3:0]  fq;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [11:0] ins, input logic [3:0] af, input logic mr, input state_t st,
                   input logic pc, input logic ir, input logic mw, input logic rw, input logic adr,
                   input logic [1:0] res, input logic a, input logic [1:0] b, input logic [3:0] alu,
                   input logic lk, input logic [3:0] fq);
    vec_t t;
    t.ins  = ins;
    t.af   = af;
    t.mr   = mr;
    t.st   = st;
    t.ctrl = {pc, ir, mw, rw, adr, res, a, b, alu, lk};
    t.fq   = fq;
    vecs.push_back(t);
  endtask

  task automatic vf(input logic [11:0] ins, input logic mr, input logic [3:0] fq);
    v(ins, 4'b0000, mr, FETCH, mr, mr, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0100, 1'b0, fq);
  endtask

  task automatic vd(input logic [11:0] ins, input logic [3:0] fq);
    v(ins, 4'b0000, 1'b1, DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 4'b0100, 1'b0, fq);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_now();
    return {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.adr_src, bus.result_src,
            bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.link_sel};
  endfunction

  initial begin
    // ADD R1,R2,#5
    vf(I_ADD, 1'b1, 4'b0000); vd(I_ADD, 4'b0000);
    v(I_ADD, 4'b0000, 1'b1, EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0100, 1'b0, 4'b0000);
    v(I_ADD, 4'b0000, 1'b1, ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0000);
    // SUBS with Z result
    vf(I_SUBS, 1'b1, 4'b0000); vd(I_SUBS, 4'b0000);
    v(I_SUBS, 4'b0100, 1'b1, EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b0, 4'b0000);
    v(I_SUBS, 4'b1111, 1'b1, ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b0100);
    // BEQ taken, BNE not taken
    vf(I_BEQ, 1'b1, 4'b0100); vd(I_BEQ, 4'b0100);
    v(I_BEQ, 4'b1111, 1'b1, BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0100, 1'b0, 4'b0100);
    vf(I_BNE, 1'b1, 4'b0100); vd(I_BNE, 4'b0100);
    // CMP sets N,V, no writeback
    vf(I_CMP, 1'b1, 4'b0100); vd(I_CMP, 4'b0100);
    v(I_CMP, 4'b1001, 1'b1, EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1010, 1'b0, 4'b0100);
    // LDRMI, U=0, two stalls in MEMRD
    vf(I_LDR, 1'b1, 4'b1001); vd(I_LDR, 4'b1001);
    v(I_LDR, 4'b0000, 1'b1, MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0010, 1'b0, 4'b1001);
    v(I_LDR, 4'b0000, 1'b0, MEMRD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    v(I_LDR, 4'b0000, 1'b0, MEMRD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    v(I_LDR, 4'b0000, 1'b1, MEMRD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    v(I_LDR, 4'b0000, 1'b1, MEMWB,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    // STR with a stalled fetch and one stall in MEMWR
    vf(I_STR, 1'b0, 4'b1001); vf(I_STR, 1'b1, 4'b1001); vd(I_STR, 4'b1001);
    v(I_STR, 4'b0000, 1'b1, MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0100, 1'b0, 4'b1001);
    v(I_STR, 4'b0000, 1'b0, MEMWR,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    v(I_STR, 4'b0000, 1'b1, MEMWR,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0100, 1'b0, 4'b1001);
    // BL
    vf(I_BL, 1'b1, 4'b1001); vd(I_BL, 4'b1001);
    v(I_BL, 4'b0000, 1'b1, BRANCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0100, 1'b1, 4'b1001);
    // Undefined op and never-condition both drop back to FETCH
    vf(I_UND, 1'b1, 4'b1001); vd(I_UND, 4'b1001);
    vf(I_NV, 1'b1, 4'b1001);  vd(I_NV, 4'b1001);

    {bus.op, bus.funct, bus.cond} = I_ADD;
    bus.alu_flags = 4'b0000;
    bus.mem_ready = 1'b1;
    #2;
    chk("reset_state", 0, 32'(bus.state_q), 32'(FETCH));
    chk("reset_flags", 0, 32'(bus.flags_q), 32'h0);
    chk("reset_enables", 0, 32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      {bus.op, bus.funct, bus.cond} = vecs[i].ins;
      bus.alu_flags = vecs[i].af;
      bus.mem_ready = vecs[i].mr;
      @(negedge clk);
      chk("state", i, 32'(bus.state_q), 32'(vecs[i].st));
      chk("ctrl", i, 32'(ctrl_now()), 32'(vecs[i].ctrl));
      chk("flags", i, 32'(bus.flags_q), 32'(vecs[i].fq));
      chk("src_sel", i, 32'({bus.reg_src, bus.imm_src}),
          32'({(vecs[i].ins[11:10] == 2'b10), (vecs[i].ins[11:10] == 2'b01), vecs[i].ins[11:10]}));
      @(posedge clk); #1;
    end

    // STR aborted by reset in MEMADR
    {bus.op, bus.funct, bus.cond} = I_STR;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("abort_fetch", 0, 32'(bus.state_q), 32'(FETCH));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_memadr", 0, 32'(bus.state_q), 32'(MEMADR));
    #1 rst = 1'b0;
    #1;
    chk("abort_state", 1, 32'(bus.state_q), 32'(FETCH));
    chk("abort_flags", 1, 32'(bus.flags_q), 32'h0);
    chk("abort_enables", 1, 32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_hold_state", 2, 32'(bus.state_q), 32'(FETCH));
    chk("abort_hold_enables", 2, 32'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("restart_state", 3, 32'(bus.state_q), 32'(FETCH));
    chk("restart_ctrl", 3, 32'({bus.pc_write, bus.ir_write, bus.mem_write}), 32'b110);
    @(posedge clk); #1;
    chk("restart_decode", 4, 32'(bus.state_q), 32'(DECODE));
    chk("restart_mem_write", 4, 32'(bus.mem_write), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
